pulse_sched_fifo: RTL and testbench
===================================

Name: pulse_sched_fifo

Overview:
- Sits directly downstream of the pulse parameter register stage and captures one pulse command whenever that stage strobes (cstrobe).
- Each command carries phase, freq, amp, env_word and cfg, and is tagged with a trigger time.
- Commands are buffered in order and released to the element (DAC/envelope) interface exactly when the global time counter reaches each command's trigger time.
- This decouples processor issue timing from pulse play timing.

Parameters:
- PHASE_WIDTH, 17, phase word width.
- FREQ_WIDTH, 9, freq word width.
- AMP_WIDTH, 16, amplitude word width.
- ENV_WORD_WIDTH, 24, envelope word (12b addr + 12b length).
- CFG_WIDTH, 4, mode + dest bits.
- TIME_WIDTH, 32, width of trigger time and time counter.
- FIFO_DEPTH, 8, number of buffered commands; must be a power of 2, minimum 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-high reset.
- cstrobe_in  in  1  push strobe from the pulse register stage.
- phase_in  in  PHASE_WIDTH  pulse phase.
- freq_in  in  FREQ_WIDTH  pulse frequency index.
- amp_in  in  AMP_WIDTH  pulse amplitude.
- env_word_in  in  ENV_WORD_WIDTH  envelope word.
- cfg_in  in  CFG_WIDTH  pulse cfg.
- trig_time_in  in  TIME_WIDTH  absolute trigger time of the pushed command.
- cur_time  in  TIME_WIDTH  global time counter; increments by 1 per clk, wraps.
- flush  in  1  synchronous queue clear.
- phase  out  PHASE_WIDTH  released pulse phase (registered).
- freq  out  FREQ_WIDTH  released frequency (registered).
- amp  out  AMP_WIDTH  released amplitude (registered).
- env_word  out  ENV_WORD_WIDTH  released envelope word (registered).
- cfg  out  CFG_WIDTH  released cfg (registered).
- cstrobe  out  1  one-cycle strobe marking a release.
- count  out  log2(FIFO_DEPTH)+1  current occupancy.
- full  out  1  count == FIFO_DEPTH.
- empty  out  1  count == 0.
- overflow_err  out  1  sticky: push dropped because the queue was full.
- late_err  out  1  sticky: command pushed with a trigger time already passed.

Behaviour:
- Reset (async assert, sync-to-clk deassert handled outside the block): all data outputs 0, cstrobe 0, count 0, empty 1, full 0, both error flags 0, read and write pointers 0. Storage contents are don't-care.
- Storage: circular buffer with wrapping read/write pointers.
  - Entry = {trig_time, env_word, phase, freq, amp, cfg}.
  - Pointers wrap modulo FIFO_DEPTH.
- Push:
  - On posedge with cstrobe_in=1: if not full, or a pop occurs in the same cycle, write the entry at wptr and increment wptr.
  - Otherwise drop the command and set overflow_err.
- Late detection:
  - At push, compute the signed difference d = trig_time_in - cur_time over TIME_WIDTH bits, wrap-safe.
  - If d < 0, set late_err. The entry is still queued.
- Release (pop) condition: queue non-empty AND signed (cur_time - head.trig_time) >= 0. Wrap-safe compare; the window is half the time range.
  - On a pop edge: register the head fields onto the outputs, assert cstrobe for exactly one cycle, increment rptr.
  - At most one pop per cycle. A late head pops as soon as it becomes the head.
- Latency: a command pushed on edge N with its trigger time already reached appears on the outputs with cstrobe=1 after edge N+1, i.e. 1 cycle of store + 1 cycle of release.
  - Command with trig_time T pushed early: cstrobe is high in the cycle following the edge where cur_time == T.
- Ordering: strict FIFO.
  - A later entry with an earlier trigger time waits behind the head and is released late. late_err is not set for this case.
- Outputs hold their last released values between strobes.
- count: increments on push-only, decrements on pop-only, unchanged on simultaneous push+pop.
- Simultaneous push+pop:
  - When full, both proceed; count stays FIFO_DEPTH.
  - When empty, the push proceeds and no pop occurs that cycle; the empty queue is never read.
- flush:
  - On the edge where flush=1: pointers and count go to 0 and cstrobe goes to 0.
  - A cstrobe_in on that same cycle is discarded.
  - Error flags are also cleared.
  - Data outputs keep their values.
- Reset mid-operation: asserting reset clears the queue immediately, regardless of pending entries.

Test Plan:
- Reset, then push {phase=0x1_2345, freq=0x1A, amp=0x7FFF, env=0x010_020, cfg=0x3, trig=100} at cur_time=50 -> cstrobe high for 1 cycle in the cycle after the edge with cur_time=100; outputs match; count returns 0.
- Push 3 commands back-to-back with trig=200,210,205 -> strobes at 200 and 210, then 205's entry releases immediately after (cycle after cur_time=210 edge+1); late_err stays 0.
- Push 9 commands (depth 8) with trig=1000 while cur_time=0 -> 9th dropped, overflow_err=1, full=1, count=8; 8 strobes on consecutive cycles starting at 1000.
- Push with trig=5 at cur_time=40 -> late_err=1; cstrobe 2 cycles after cstrobe_in.
- cur_time near wrap: push trig=0x0000_0002 at cur_time=0xFFFF_FFF0 -> no early release; strobe after cur_time=2.
- Queue holds 4 entries, assert flush together with cstrobe_in -> count=0, empty=1, no strobe follows, pushed command lost; errors cleared.

Source files
------------

// File: rtl/pulse_sched_fifo.sv
// pulse_sched_fifo: time-tagged pulse command queue releasing each command when cur_time reaches its trigger.
module pulse_sched_fifo #(
  parameter int PHASE_WIDTH    = 17,
  parameter int FREQ_WIDTH     = 9,
  parameter int AMP_WIDTH      = 16,
  parameter int ENV_WORD_WIDTH = 24,
  parameter int CFG_WIDTH      = 4,
  parameter int TIME_WIDTH     = 32,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cstrobe_in,
  input  logic [PHASE_WIDTH-1:0]        phase_in,
  input  logic [FREQ_WIDTH-1:0]         freq_in,
  input  logic [AMP_WIDTH-1:0]          amp_in,
  input  logic [ENV_WORD_WIDTH-1:0]     env_word_in,
  input  logic [CFG_WIDTH-1:0]          cfg_in,
  input  logic [TIME_WIDTH-1:0]         trig_time_in,
  input  logic [TIME_WIDTH-1:0]         cur_time,
  input  logic                          flush,
  output logic [PHASE_WIDTH-1:0]        phase,
  output logic [FREQ_WIDTH-1:0]         freq,
  output logic [AMP_WIDTH-1:0]          amp,
  output logic [ENV_WORD_WIDTH-1:0]     env_word,
  output logic [CFG_WIDTH-1:0]          cfg,
  output logic                          cstrobe,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty,
  output logic                          overflow_err,
  output logic                          late_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = ENV_WORD_WIDTH + PHASE_WIDTH + FREQ_WIDTH + AMP_WIDTH + CFG_WIDTH;
  localparam int EW = TIME_WIDTH + PW;
  logic [EW-1:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr, r_rptr;
  logic [EW-1:0]         w_head;
  logic [TIME_WIDTH-1:0] w_wait, w_lead;
  logic                  w_pop, w_push, w_drop;
  assign w_head = r_mem[r_rptr];
  // Sign bit of the modular difference gives a wrap-safe half-range compare
  assign w_wait = cur_time - w_head[EW-1 -: TIME_WIDTH];
  assign w_lead = trig_time_in - cur_time;
  assign w_pop  = !flush && !empty && !w_wait[TIME_WIDTH-1];
  assign w_push = cstrobe_in && !flush && (!full || w_pop);
  assign w_drop = cstrobe_in && !flush && full && !w_pop;
  assign full   = count == (AW+1)'(FIFO_DEPTH);
  assign empty  = count == '0;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wptr] <= {trig_time_in, env_word_in, phase_in, freq_in, amp_in, cfg_in};
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      count        <= '0;
      cstrobe      <= 1'b0;
      overflow_err <= 1'b0;
      late_err     <= 1'b0;
      {env_word, phase, freq, amp, cfg} <= '0;
    end else if (flush) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      count        <= '0;
      cstrobe      <= 1'b0;
      overflow_err <= 1'b0;
      late_err     <= 1'b0;
    end else begin
      cstrobe <= w_pop;
      count   <= count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        {env_word, phase, freq, amp, cfg} <= w_head[PW-1:0];
      end
      if (w_drop) overflow_err <= 1'b1;
      if (w_push && w_lead[TIME_WIDTH-1]) late_err <= 1'b1;
    end
endmodule

// File: tb/tb_pulse_sched_fifo.sv
// tb_pulse_sched_fifo: queue-based reference model with a scoreboard monitor for pulse_sched_fifo.
module tb_pulse_sched_fifo;
  logic        clk = 0, reset = 1, cstrobe_in = 0, flush = 0;
  logic [16:0] phase_in = 0, phase;
  logic [8:0]  freq_in = 0, freq;
  logic [15:0] amp_in = 0, amp;
  logic [23:0] env_word_in = 0, env_word;
  logic [3:0]  cfg_in = 0, cfg;
  logic [31:0] trig_time_in = 0, cur_time = 0, tnext = 0;
  logic        cstrobe, full, empty, overflow_err, late_err;
  logic [3:0]  count;
  int          tests = 0, fails = 0;

  typedef struct {
    logic [31:0] t;
    logic [16:0] ph;
    logic [8:0]  fr;
    logic [15:0] am;
    logic [23:0] en;
    logic [3:0]  cf;
  } cmd_t;
  cmd_t mq[$], eq[$], m_last, c_in, c_out, c_mon;
  logic m_strobe = 0, m_ovf = 0, m_late = 0;
  logic [31:0] d;

  pulse_sched_fifo dut (
    .clk(clk), .reset(reset), .cstrobe_in(cstrobe_in), .phase_in(phase_in), .freq_in(freq_in),
    .amp_in(amp_in), .env_word_in(env_word_in), .cfg_in(cfg_in), .trig_time_in(trig_time_in),
    .cur_time(cur_time), .flush(flush), .phase(phase), .freq(freq), .amp(amp), .env_word(env_word),
    .cfg(cfg), .cstrobe(cstrobe), .count(count), .full(full), .empty(empty),
    .overflow_err(overflow_err), .late_err(late_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t cur_time=%0d)", n, a, e, $time, cur_time);
    end
  endtask

  // Reference model: plain in-order queue, head released once its time is not in the future.
  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      eq.delete();
      m_strobe = 0;
      m_ovf = 0;
      m_late = 0;
      m_last = '{default: 0};
    end else if (flush) begin
      mq.delete();
      m_strobe = 0;
      m_ovf = 0;
      m_late = 0;
    end else begin
      m_strobe = 0;
      if (mq.size() > 0) begin
        d = cur_time - mq[0].t;
        if ($signed(d) >= 0) begin
          c_out = mq.pop_front();
          eq.push_back(c_out);
          m_last = c_out;
          m_strobe = 1;
        end
      end
      if (cstrobe_in) begin
        if (mq.size() < 8) begin
          c_in = '{trig_time_in, phase_in, freq_in, amp_in, env_word_in, cfg_in};
          mq.push_back(c_in);
          d = trig_time_in - cur_time;
          if ($signed(d) < 0) m_late = 1;
        end else m_ovf = 1;
      end
    end
  end

  // Monitor: compares DUT outputs mid-cycle against the model and expected-release queue.
  always @(negedge clk) begin
    if (!reset) begin
      chk("cstrobe", cstrobe, m_strobe);
      if (cstrobe) begin
        if (eq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got cstrobe=1 expected no release (t=%0t)", $time);
        end else begin
          c_mon = eq.pop_front();
          chk("rel_phase", phase, c_mon.ph);
          chk("rel_freq", freq, c_mon.fr);
          chk("rel_amp", amp, c_mon.am);
          chk("rel_env", env_word, c_mon.en);
          chk("rel_cfg", cfg, c_mon.cf);
        end
      end else begin
        eq.delete();
        chk("hold_data", {phase, freq, amp, env_word, cfg},
            {m_last.ph, m_last.fr, m_last.am, m_last.en, m_last.cf});
      end
      chk("count", count, mq.size());
      chk("full", full, mq.size() == 8);
      chk("empty", empty, mq.size() == 0);
      chk("overflow_err", overflow_err, m_ovf);
      chk("late_err", late_err, m_late);
    end
  end

  task automatic step(input bit r, input bit p, input bit f, input logic [31:0] tt);
    @(negedge clk);
    #1;
    reset = r;
    cstrobe_in = p;
    flush = f;
    trig_time_in = tt;
    cur_time = tnext;
    tnext = tnext + 1;
    phase_in = 17'($urandom);
    freq_in = 9'($urandom);
    amp_in = 16'($urandom);
    env_word_in = 24'($urandom);
    cfg_in = 4'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0);
  endtask

  initial begin
    repeat (3) step(1, 0, 0, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_cstrobe", cstrobe, 0);
    chk("rst_errs", {overflow_err, late_err}, 0);
    chk("rst_data", {phase, freq, amp, env_word, cfg}, 0);
    tnext = 50;
    step(0, 1, 0, 100);
    phase_in = 17'h12345;
    freq_in = 9'h1A;
    amp_in = 16'h7FFF;
    env_word_in = 24'h010020;
    cfg_in = 4'h3;
    idle(60);
    chk("t1_phase", phase, 17'h12345);
    chk("t1_count", count, 0);
    tnext = 190;
    step(0, 1, 0, 200);
    step(0, 1, 0, 210);
    step(0, 1, 0, 205);
    idle(30);
    chk("t2_late", late_err, 0);
    tnext = 0;
    repeat (9) step(0, 1, 0, 1000);
    idle(1);
    chk("t3_overflow", overflow_err, 1);
    chk("t3_full", full, 1);
    chk("t3_count", count, 8);
    tnext = 990;
    idle(25);
    chk("t3_drained", count, 0);
    tnext = 40;
    step(0, 1, 0, 5);
    idle(4);
    chk("t4_late", late_err, 1);
    tnext = 32'hFFFF_FFF0;
    step(0, 1, 0, 2);
    idle(25);
    tnext = 500;
    repeat (4) step(0, 1, 0, 2000);
    step(0, 1, 1, 600);
    idle(1);
    chk("t6_count", count, 0);
    chk("t6_empty", empty, 1);
    chk("t6_errs", {overflow_err, late_err}, 0);
    idle(5);
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 199) == 0, $urandom_range(0, 1), $urandom_range(0, 49) == 0,
           tnext + $urandom_range(0, 40) - 5);
    idle(60);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
